// File: rtl/writeback_stage.sv
// writeback_stage: buffers MEM-stage results in a DEPTH-entry FIFO and retires them to the register file.
// Latency: 2 edges minimum (accepted at edge N, popped at N+1, reg_write_en high from N+1 to N+2).
// Backpressure: in_ready is registered (count < DEPTH); wb_hold only stalls pops and never reaches in_ready combinationally.
// Ports: clk, reset (async, active-low); in_valid/in_ready handshake with in_reg_write, in_dest, in_mem_to_reg,
//   in_alu_result, in_mem_data, in_ld_size, in_ld_signed, in_byte_off; wb_hold from the register file;
//   write_reg/write_data/reg_write_en register-file write port; chk_reg_1/chk_reg_2 -> hazard; wb_count retired writes.
module writeback_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_reg_write,
   input  logic [4:0]  in_dest,
   input  logic        in_mem_to_reg,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_mem_data,
   input  logic [1:0]  in_ld_size,
   input  logic        in_ld_signed,
   input  logic [1:0]  in_byte_off,
   input  logic        wb_hold,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data,
   output logic        reg_write_en,
   input  logic [4:0]  chk_reg_1,
   input  logic [4:0]  chk_reg_2,
   output logic        hazard,
   output logic [31:0] wb_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // FIFO storage; entries are tracked by r_vld so the hazard check can scan them directly
   logic [4:0]       r_dest [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             r_in_ready;

   // register-file write port
   logic             r_we;
   logic [4:0]       r_wreg;
   logic [31:0]      r_wdata;
   logic [31:0]      r_wb_count;

   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_next_count;
   logic [31:0]      w_load_data;
   logic             w_hazard;

   // Load alignment and extension. Only the final value is needed at pop time, so it is
   // computed once on entry and stored; the popped value is identical either way.
   function automatic logic [31:0] f_align(
      input logic        mem_to_reg,
      input logic [31:0] alu,
      input logic [31:0] mem,
      input logic [1:0]  size,
      input logic [1:0]  off,
      input logic        sgn
   );
      logic [15:0] half_v;
      logic [7:0]  byte_v;
      logic [31:0] res;
      half_v = off[1] ? mem[31:16] : mem[15:0];
      case (off)
         2'd0:    byte_v = mem[7:0];
         2'd1:    byte_v = mem[15:8];
         2'd2:    byte_v = mem[23:16];
         default: byte_v = mem[31:24];
      endcase
      if (!mem_to_reg) begin
         res = alu;
      end else begin
         case (size)
            2'b01:   res = {{16{sgn & half_v[15]}}, half_v};
            2'b10:   res = {{24{sgn & byte_v[7]}}, byte_v};
            default: res = mem;   // 00 word, 11 treated as word
         endcase
      end
      return res;
   endfunction

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_load_data = f_align(in_mem_to_reg, in_alu_result, in_mem_data,
                                in_ld_size, in_byte_off, in_ld_signed);

   // Results that write nothing (no reg_write or x0) complete the handshake but are dropped here.
   assign w_push       = in_valid && r_in_ready && in_reg_write && (in_dest != 5'd0);
   assign w_pop        = !wb_hold && (r_count != '0);
   assign w_next_count = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_vld      <= '0;
         r_in_ready <= 1'b0;
         r_we       <= 1'b0;
         r_wreg     <= 5'd0;
         r_wdata    <= 32'd0;
         r_wb_count <= 32'd0;
      end else begin
         r_count    <= w_next_count;
         // ready is derived from the post-edge occupancy, so a pop frees a slot for the next cycle only
         r_in_ready <= (w_next_count < CW'(DEPTH));
         if (w_push) begin
            r_wr_ptr        <= f_inc(r_wr_ptr);
            r_vld[r_wr_ptr] <= 1'b1;
         end
         // push and pop never target the same slot: a full FIFO cannot push
         if (w_pop) begin
            r_rd_ptr        <= f_inc(r_rd_ptr);
            r_vld[r_rd_ptr] <= 1'b0;
            r_we            <= 1'b1;
            r_wreg          <= r_dest[r_rd_ptr];
            r_wdata         <= r_data[r_rd_ptr];
            r_wb_count      <= r_wb_count + 32'd1;
         end else begin
            r_we <= 1'b0;
         end
      end
   end

   // payload storage needs no reset; r_vld qualifies every read of it
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_dest[r_wr_ptr] <= in_dest;
         r_data[r_wr_ptr] <= w_load_data;
      end
   end

   // A register is still "in flight" while queued or while its write pulse is on the port.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (((chk_reg_1 != 5'd0) && (r_dest[i] == chk_reg_1)) ||
                          ((chk_reg_2 != 5'd0) && (r_dest[i] == chk_reg_2)))) begin
            w_hazard = 1'b1;
         end
      end
      if (r_we && (((chk_reg_1 != 5'd0) && (r_wreg == chk_reg_1)) ||
                   ((chk_reg_2 != 5'd0) && (r_wreg == chk_reg_2)))) begin
         w_hazard = 1'b1;
      end
   end

   assign in_ready     = r_in_ready;
   assign reg_write_en = r_we;
   assign write_reg    = r_wreg;
   assign write_data   = r_wdata;
   assign wb_count     = r_wb_count;
   assign hazard       = w_hazard;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_reg_write, in_mem_to_reg, in_ld_signed, wb_hold;
   logic [4:0]  in_dest, chk_reg_1, chk_reg_2;
   logic [31:0] in_alu_result, in_mem_data;
   logic [1:0]  in_ld_size, in_byte_off;
   logic        in_ready, reg_write_en, hazard;
   logic [4:0]  write_reg;
   logic [31:0] write_data, wb_count;

   always #5 clk = ~clk;

   writeback_stage #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write), .in_dest(in_dest),
      .in_mem_to_reg(in_mem_to_reg), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
      .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed), .in_byte_off(in_byte_off),
      .wb_hold(wb_hold), .write_reg(write_reg), .write_data(write_data), .reg_write_en(reg_write_en),
      .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2), .hazard(hazard), .wb_count(wb_count)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model: a queue of pending writes ----------------
   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
   } wr_t;

   wr_t         q[$];
   logic        m_ready, m_we;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdata, m_cnt;

   function automatic logic [31:0] ref_data(input logic m2r, input logic [31:0] alu, input logic [31:0] mem,
                                            input logic [1:0] sz, input logic [1:0] off, input logic sgn);
      int unsigned width, shift, modv, v;
      if (!m2r) return alu;
      if (sz == 2'b01) begin
         width = 16;
         shift = off[1] ? 16 : 0;
      end else if (sz == 2'b10) begin
         width = 8;
         shift = 8 * int'(off);
      end else begin
         return mem;
      end
      modv = 32'd1 << width;
      v    = (mem >> shift) % modv;
      if (sgn && v >= modv / 2) v = v - modv;   // wraps to two's complement
      return v;
   endfunction

   function automatic logic ref_hazard(input logic [4:0] c1, input logic [4:0] c2);
      logic h;
      h = 1'b0;
      foreach (q[i]) begin
         if (c1 != 0 && q[i].dest == c1) h = 1'b1;
         if (c2 != 0 && q[i].dest == c2) h = 1'b1;
      end
      if (m_we && ((c1 != 0 && m_wreg == c1) || (c2 != 0 && m_wreg == c2))) h = 1'b1;
      return h;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ready = 1'b0;
      m_we    = 1'b0;
      m_wreg  = 5'd0;
      m_wdata = 32'd0;
      m_cnt   = 32'd0;
   endtask

   task automatic model_edge();
      logic acc;
      wr_t  e;
      acc = in_valid && m_ready;
      if (!wb_hold && q.size() > 0) begin
         e       = q.pop_front();
         m_we    = 1'b1;
         m_wreg  = e.dest;
         m_wdata = e.data;
         m_cnt   = m_cnt + 32'd1;
      end else begin
         m_we = 1'b0;
      end
      if (acc && in_reg_write && in_dest != 5'd0) begin
         e.dest = in_dest;
         e.data = ref_data(in_mem_to_reg, in_alu_result, in_mem_data, in_ld_size, in_byte_off, in_ld_signed);
         q.push_back(e);
      end
      m_ready = (q.size() < DEPTH);
   endtask

   task automatic check_all();
      check_eq("in_ready", in_ready, m_ready);
      check_eq("reg_write_en", reg_write_en, m_we);
      check_eq("write_reg", write_reg, m_wreg);
      check_eq("write_data", write_data, m_wdata);
      check_eq("wb_count", wb_count, m_cnt);
      check_eq("hazard", hazard, ref_hazard(chk_reg_1, chk_reg_2));
   endtask

   // one clock: model follows the edge, outputs checked on the falling edge
   task automatic step();
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic offer(input logic [4:0] d, input logic rw, input logic m2r, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [1:0] sz, input logic [1:0] off, input logic sgn);
      in_valid      = 1'b1;
      in_dest       = d;
      in_reg_write  = rw;
      in_mem_to_reg = m2r;
      in_alu_result = alu;
      in_mem_data   = mem;
      in_ld_size    = sz;
      in_byte_off   = off;
      in_ld_signed  = sgn;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   logic [1:0]  ld_sz  [4];
   logic [1:0]  ld_off [4];
   logic        ld_sgn [4];
   logic [31:0] ld_exp [4];

   initial begin
      logic acc;
      int   k, nret, c0;
      logic [31:0] cnt_before;

      ld_sz  = '{2'b10, 2'b10, 2'b01, 2'b01};
      ld_off = '{2'd0, 2'd0, 2'd2, 2'd3};
      ld_sgn = '{1'b1, 1'b0, 1'b1, 1'b0};
      ld_exp = '{32'hFFFF_FFA2, 32'h0000_00A2, 32'hFFFF_80F1, 32'h0000_80F1};

      reset = 1'b1;
      wb_hold = 1'b0; chk_reg_1 = 5'd0; chk_reg_2 = 5'd0;
      offer(5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0);
      idle();
      #2 reset = 1'b0;
      #2;
      model_reset();
      check_eq("rst_in_ready", in_ready, 32'd0);
      check_eq("rst_we", reg_write_en, 32'd0);
      check_eq("rst_wreg", write_reg, 32'd0);
      check_eq("rst_wdata", write_data, 32'd0);
      check_eq("rst_count", wb_count, 32'd0);
      step();
      step();
      reset = 1'b1;
      step();
      check_eq("ready_after_rst", in_ready, 32'd1);

      // single ALU write to x8
      offer(5'd8, 1'b1, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF, 2'd0, 2'd0, 1'b0);
      step();
      idle();
      check_eq("alu_not_yet", reg_write_en, 32'd0);
      step();
      check_eq("alu_we", reg_write_en, 32'd1);
      check_eq("alu_wreg", write_reg, 32'd8);
      check_eq("alu_wdata", write_data, 32'd5);
      check_eq("alu_count", wb_count, 32'd1);
      step();
      check_eq("alu_pulse_end", reg_write_en, 32'd0);

      // load alignment / extension
      for (int i = 0; i < 4; i++) begin
         offer(5'(3 + i), 1'b1, 1'b1, 32'h1234_5678, 32'h80F1_7FA2, ld_sz[i], ld_off[i], ld_sgn[i]);
         step();
         idle();
         step();
         check_eq($sformatf("load%0d_we", i), reg_write_en, 32'd1);
         check_eq($sformatf("load%0d_data", i), write_data, ld_exp[i]);
      end
      step();

      // backpressure: hold while three results are offered
      wb_hold = 1'b1;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         offer(5'(10 + k), 1'b1, 1'b0, 32'(100 + k), 32'd0, 2'd0, 2'd0, 1'b0);
         acc = m_ready;
         step();
         check_eq("bp_hold_no_we", reg_write_en, 32'd0);
         if (acc) k++;
      end
      check_eq("bp_accepted", k, 32'd2);
      check_eq("bp_full_ready", in_ready, 32'd0);
      wb_hold = 1'b0;
      nret = 0;
      c0 = -1;
      for (int c = 0; c < 12 && nret < 3; c++) begin
         if (k < 3) offer(5'(10 + k), 1'b1, 1'b0, 32'(100 + k), 32'd0, 2'd0, 2'd0, 1'b0);
         else idle();
         acc = m_ready && (k < 3);
         step();
         if (acc) k++;
         if (reg_write_en) begin
            if (c0 < 0) c0 = c;
            check_eq("bp_order_reg", write_reg, 32'(10 + nret));
            check_eq("bp_consecutive", c, 32'(c0 + nret));
            nret++;
         end
      end
      idle();
      check_eq("bp_retired", nret, 32'd3);
      step();

      // x0 destination is handshaken but dropped
      cnt_before = m_cnt;
      chk_reg_1 = 5'd0;
      offer(5'd0, 1'b1, 1'b0, 32'h0000_0077, 32'd0, 2'd0, 2'd0, 1'b0);
      step();
      idle();
      check_eq("x0_hazard", hazard, 32'd0);
      step();
      check_eq("x0_no_we", reg_write_en, 32'd0);
      check_eq("x0_count", wb_count, cnt_before);
      step();

      // hazard on dest 18 while queued and while writing
      chk_reg_1 = 5'd19;
      chk_reg_2 = 5'd18;
      wb_hold = 1'b1;
      offer(5'd18, 1'b1, 1'b0, 32'h0000_0018, 32'd0, 2'd0, 2'd0, 1'b0);
      step();
      idle();
      check_eq("haz_queued", hazard, 32'd1);
      chk_reg_2 = 5'd0;
      #1 check_eq("haz_other_reg", hazard, 32'd0);
      chk_reg_2 = 5'd18;
      #1 check_eq("haz_restored", hazard, 32'd1);
      step();
      check_eq("haz_held", hazard, 32'd1);
      wb_hold = 1'b0;
      step();
      check_eq("haz_write_pulse", reg_write_en, 32'd1);
      check_eq("haz_during_write", hazard, 32'd1);
      step();
      check_eq("haz_cleared", hazard, 32'd0);
      chk_reg_1 = 5'd0;
      chk_reg_2 = 5'd0;

      // reset with two entries in flight
      wb_hold = 1'b1;
      offer(5'd20, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 2'd0, 2'd0, 1'b0);
      step();
      offer(5'd21, 1'b1, 1'b0, 32'h0000_0021, 32'd0, 2'd0, 2'd0, 1'b0);
      step();
      idle();
      wb_hold = 1'b0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_eq("midrst_we", reg_write_en, 32'd0);
      check_eq("midrst_wdata", write_data, 32'd0);
      check_eq("midrst_count", wb_count, 32'd0);
      check_eq("midrst_ready", in_ready, 32'd0);
      step();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq("midrst_no_write", reg_write_en, 32'd0);
      end

      // randomized traffic against the queue model
      for (int c = 0; c < 600; c++) begin
         offer(5'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0), 1'($urandom),
               $urandom, $urandom, 2'($urandom), 2'($urandom), 1'($urandom));
         in_valid  = ($urandom_range(0, 3) != 0);
         wb_hold   = ($urandom_range(0, 9) < 3);
         chk_reg_1 = 5'($urandom_range(0, 7));
         chk_reg_2 = 5'($urandom_range(0, 7));
         step();
      end
      idle();
      wb_hold = 1'b0;
      step();
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the number of buffer entries (fixed at 2 for this release).
REQ-002 SHALL have ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream (MEM stage) result valid.
- in_ready  output  1  stage can accept a result.
- in_reg_write  input  1  result writes a register.
- in_dest  input  5  destination register number.
- in_mem_to_reg  input  1  1 = load data, 0 = ALU result.
- in_alu_result  input  32  ALU result.
- in_mem_data  input  32  raw memory word.
- in_ld_size  input  2  00 word, 01 half, 10 byte, 11 treated as word.
- in_ld_signed  input  1  sign-extend sub-word loads.
- in_byte_off  input  2  address bits [1:0] of the load.
- wb_hold  input  1  register file cannot accept a write this cycle.
- write_reg  output  5  register file write address.
- write_data  output  32  register file write data.
- reg_write_en  output  1  register file write enable.
- chk_reg_1, chk_reg_2  input  5 each  decode-stage source registers to check.
- hazard  output  1  a checked register has a write in flight.
- wb_count  output  32  retired-write counter.

Function
REQ-003 SHALL accept a result on a rising edge where in_valid and in_ready are both 1, pushing it into a DEPTH-entry FIFO.
REQ-004 SHALL drive in_ready = 1 iff the FIFO count is below DEPTH, registered and without a combinational path from wb_hold.
REQ-005 SHALL discard accepted results with in_reg_write = 0 or in_dest = 0 (no push, no count); they are still handshaken.
REQ-006 SHALL, on each rising edge with wb_hold = 0 and FIFO non-empty, pop the head into the output register and set reg_write_en = 1 for exactly that following cycle.
REQ-007 SHALL deassert reg_write_en on any edge where no pop occurs, including all edges with wb_hold = 1. write_reg and write_data SHALL hold their last values.
REQ-008 SHALL give a minimum latency of 2 edges: accepted at edge N, popped at edge N+1, and reg_write_en high during cycle N+1 to N+2. The register file samples on the falling edge in between.
REQ-009 SHALL allow push and pop on the same edge. The count is unchanged. When full, in_ready = 0, so there is no push that cycle, even with a pop.
REQ-010 SHALL compute write_data at pop as follows:
- in_mem_to_reg = 0: the ALU result.
- Word: mem data unchanged.
- Half: bits [15:0] if byte_off[1] = 0, else bits [31:16]; byte_off[0] is ignored.
- Byte: byte byte_off (0 = bits [7:0]).
- Sub-word values are zero- or sign-extended per in_ld_signed.
REQ-011 SHALL drive hazard combinationally as 1 when a nonzero chk_reg_1 or chk_reg_2 matches the dest of any valid FIFO entry, or matches write_reg while reg_write_en = 1. Register 0 never hazards.
REQ-012 SHALL increment wb_count by 1 per pop, wrapping from 0xFFFFFFFF to 0.
REQ-013 SHALL preserve FIFO order. Duplicate dests in flight are legal, and the last write wins.

Reset
REQ-014 SHALL, while reset = 0, asynchronously clear:
- FIFO count, read and write pointers.
- reg_write_en = 0, write_reg = 0, write_data = 0.
- wb_count = 0.
- in_ready = 0.
REQ-015 SHALL set in_ready = 1 on the first rising edge after reset deasserts.
REQ-016 SHALL lose any in-flight results on reset mid-operation, with no partial write.

Verification
REQ-017 Single ALU write: in_dest = 8, alu = 0x0000_0005, accepted at edge 1 -> reg_write_en = 1 in cycle after edge 2, write_reg = 8, write_data = 5, wb_count = 1.
REQ-018 Loads with mem = 0x80F1_7FA2:
- byte, off = 0, signed -> 0xFFFF_FFA2.
- byte, off = 0, unsigned -> 0x0000_00A2.
- half, off = 2, signed -> 0xFFFF_80F1.
- half, off = 3, unsigned -> 0x0000_80F1.
REQ-019 Backpressure: wb_hold = 1 while 3 valid results are offered:
- 2 are accepted, then in_ready = 0 and reg_write_en stays 0.
- After wb_hold is released, the writes retire in order on consecutive cycles and the third is accepted.
REQ-020 Register-0 filter: in_dest = 0 with in_reg_write = 1 -> handshake completes, no reg_write_en, wb_count unchanged, hazard = 0 for chk_reg_1 = 0.
REQ-021 Hazard: dest 18 in flight -> chk_reg_2 = 18 gives hazard = 1 until the cycle after its write pulse ends, and chk_reg_1 = 19 gives 0.
REQ-022 Reset mid-operation: FIFO holding 2 entries, reset pulsed low -> reg_write_en, write_data and wb_count read 0 immediately, and no write occurs after release.
